clk_div_bank: RTL
=================

# clk_div_bank

Lock-qualified, multi-channel clock-enable generator that sits directly behind a PLL instance. It turns one PLL output clock into NUM_CH independently programmable clock-enable strobes. A debounced `locked` status gates all strobes, so the SDRAM controller and test logic can run several slow rates from a single fast clock domain without extra PLL outputs.

## Interface
- NUM_CH, 4, number of enable channels (1..16)
- CNT_W, 16, divisor and counter width per channel
- LOCK_CYCLES, 1024, consecutive synchronized PLL-lock cycles required before `locked` asserts (>=1)
- refclk  in  1  sole clock (PLL output clock); all logic on rising edge
- rst  in  1  synchronous, active-high reset
- pll_locked  in  1  raw PLL lock, asynchronous; synchronized internally by 2 flops
- div_wr  in  1  divisor write strobe, one cycle
- div_ch  in  4  channel index for write; values >= NUM_CH ignored
- div_val  in  CNT_W  divisor value
- sync  in  1  one-cycle phase-align strobe, all channels
- locked  out  1  qualified lock status
- ce_out  out  NUM_CH  per-channel clock-enable strobes
- clk_tgl  out  NUM_CH  divided square waves; present only with CLK_DIV_BANK_TOGGLE_EN

## Operation
- Reset values: locked=0, ce_out=0, clk_tgl=0, lock counter=0, channel counters=0, all divisors=0.
- Lock qualifier:
  - While synchronized lock is 1: lock counter increments, saturating at LOCK_CYCLES.
  - `locked`=1 when counter==LOCK_CYCLES.
  - Any synchronized 0 clears the counter and drops `locked` on the next edge.
- Divisor D per channel:
  - D=0: channel disabled, ce_out=0.
  - D=1: ce_out=1 every cycle locked=1.
  - D>=2: one-cycle pulse every D cycles.
  - Max D = 2^CNT_W-1.
- Channel counter runs 0..D-1 and wraps. ce_out[i] is high in cycles where counter==D-1.
- While locked=0: all counters are held at 0 and ce_out=0.
- Write (div_wr, div_ch valid): new D is stored and that channel's counter clears to 0 on the same edge. Other channels are undisturbed.
- sync: all counters clear to 0 on the same edge, so every channel's next pulse aligns to its own D from that point.
- Simultaneous write and sync: both apply. Counters all clear, and the written channel uses the new D.
- Writing D to a disabled channel enables it from counter 0.
- Writes are accepted while locked=0. The divisor is stored, and counting starts when locked rises.

## Timing
- ce_out and locked are registered outputs, with no combinational path from any input.
- Lock assert: pll_locked rising, and held, produces locked=1 exactly LOCK_CYCLES+2 edges later (2 sync + count).
- Lock deassert: pll_locked falling produces locked=0 3 edges later. ce_out is forced 0 in the same cycle locked drops.
- First pulse after locked rises: ce_out[i] is high in the D-th cycle in which locked=1 (D=1: first locked cycle).
- After a write or sync in cycle k, the first pulse is in cycle k+D.
- Reset mid-operation: every state returns to its reset value on the next edge. The divisor must be rewritten after reset.

## Configuration
- CLK_DIV_BANK_TOGGLE_EN defined:
  - Adds the clk_tgl port and per-channel toggle flops.
  - clk_tgl[i] inverts on each ce_out[i] pulse, giving period 2*D cycles and 50% duty.
  - clk_tgl is cleared by rst, by locked=0, by write to that channel, and by sync.
- Macro undefined: no clk_tgl port and no toggle logic.

## Test plan
- Lock qualify, LOCK_CYCLES=8:
  - pll_locked high -> locked rises at edge 10.
  - Glitch low for 1 cycle at edge 6 -> locked rises 10 edges after the glitch ends.
- Divisors ch0=1, ch1=3, ch2=0, ch3=5, all written before lock:
  - After locked: ch0 high constantly.
  - ch1 pulses in locked cycles 3,6,9.
  - ch2 stays 0.
  - ch3 pulses in locked cycles 5,10.
- Mid-run write of D=2 to ch1 in cycle k -> ch1 pulses at k+2, k+4. ch3 phase is unchanged.
- sync asserted together with a write of D=4 to ch3 -> all counters clear, ch3 pulses at +4, ch1 pulses at +3.
- pll_locked drops mid-run -> locked=0 and ce_out=0 3 edges later. On relock, pulses restart from counter 0.
- div_ch=7 with NUM_CH=4 -> no divisor or counter changes. With TOGGLE_EN and D=3 -> clk_tgl period is 6 cycles.

Source files
------------

// File: rtl/clk_div_bank_if.sv
// Divisor-programming bus for clk_div_bank: write strobe, channel index,
// divisor value and the all-channel phase-align strobe.
interface clk_div_bank_if #(
  parameter int CNT_W = 16
) ();
  logic             div_wr;
  logic [3:0]       div_ch;
  logic [CNT_W-1:0] div_val;
  logic             sync;

  modport master (output div_wr, div_ch, div_val, sync);
  modport slave  (input  div_wr, div_ch, div_val, sync);
endinterface

// File: rtl/clk_div_bank.sv
// Lock-qualified bank of programmable clock-enable generators behind a PLL.
// Optional CLK_DIV_BANK_TOGGLE_EN adds clk_tgl: 50% duty divided square waves.
module clk_div_bank #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int LOCK_CYCLES = 1024
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              pll_locked,
  clk_div_bank_if.slave     bus,
  output logic              locked,
  output logic [NUM_CH-1:0] ce_out
`ifdef CLK_DIV_BANK_TOGGLE_EN
  ,
  output logic [NUM_CH-1:0] clk_tgl
`endif
);

  localparam int LCW = $clog2(LOCK_CYCLES + 1);
  localparam logic [LCW-1:0] LOCK_MAX = LCW'(LOCK_CYCLES);

  logic [1:0]        lock_sync_q, lock_sync_d;
  logic [LCW-1:0]    lock_cnt_q, lock_cnt_d;
  logic              locked_q, locked_d;
  logic [CNT_W-1:0]  div_q [NUM_CH];
  logic [CNT_W-1:0]  div_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] ce_q, ce_d;
  logic [NUM_CH-1:0] wr_hit;

  always_comb begin
    lock_sync_d = {lock_sync_q[0], pll_locked};
    if (!lock_sync_q[1]) begin
      lock_cnt_d = '0;
    end else if (lock_cnt_q == LOCK_MAX) begin
      lock_cnt_d = lock_cnt_q;
    end else begin
      lock_cnt_d = lock_cnt_q + LCW'(1);
    end
    locked_d = (lock_cnt_d == LOCK_MAX);
  end

  // Counters only advance in cycles already qualified as locked, so the first
  // locked cycle always sees counter 0; ce is decoded from the next count so
  // the strobe is registered yet lands in the cycle where counter == D-1.
  always_comb begin
    div_d  = div_q;
    cnt_d  = cnt_q;
    ce_d   = '0;
    wr_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = bus.div_wr && (bus.div_ch == 4'(i));
      if (wr_hit[i]) begin
        div_d[i] = bus.div_val;
      end
      if (!locked_q || wr_hit[i] || bus.sync || div_d[i] == '0) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= div_d[i] - CNT_W'(1)) begin
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      ce_d[i] = locked_d && (div_d[i] != '0) && (cnt_d[i] == div_d[i] - CNT_W'(1));
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_sync_q <= '0;
      lock_cnt_q  <= '0;
      locked_q    <= 1'b0;
      ce_q        <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      lock_sync_q <= lock_sync_d;
      lock_cnt_q  <= lock_cnt_d;
      locked_q    <= locked_d;
      ce_q        <= ce_d;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= div_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign locked = locked_q;
  assign ce_out = ce_q;

`ifdef CLK_DIV_BANK_TOGGLE_EN
  logic [NUM_CH-1:0] tgl_q, tgl_d;

  // Toggle phase restarts with the counters so the square wave stays aligned.
  always_comb begin
    if (!locked_d || bus.sync) begin
      tgl_d = '0;
    end else begin
      tgl_d = (tgl_q ^ ce_d) & ~wr_hit;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      tgl_q <= '0;
    end else begin
      tgl_q <= tgl_d;
    end
  end

  assign clk_tgl = tgl_q;
`endif

endmodule
